// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and iteration count for the iterative multiply/divide unit
package muldiv_pkg;
  localparam int MD_ITER = 32;
  typedef enum logic [1:0] {MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11} md_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration (is_div=0: add-shift on acc={upper,multiplier}; is_div=1: shift, trial-subtract, restore on acc={rem,quo}); opnd is multiplicand or divisor, nxt is the next acc
module muldiv_step import muldiv_pkg::*; #(
  parameter int WIDTH = MD_ITER
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] nxt
);
  logic [WIDTH:0] sum, diff;
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    nxt  = is_div ? {diff[WIDTH] ? acc[2*WIDTH-2:WIDTH-1] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]}
                  : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-step MULT/MULTU/DIV/DIVU engine owning HI/LO; start/op/rs_val/rt_val issue, rd_hilo/mt_hi/mt_lo/mt_data access HI/LO, kill aborts; busy/done/stall/hi/lo out
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = MD_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rd_hilo,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  md_state_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [WIDTH-1:0] opnd, a_abs, b_abs, quo, rem;
  logic is_div, neg_a, neg_b, dz, sgn, go;
  assign busy  = state != IDLE;
  assign stall = busy & (start | rd_hilo | mt_hi | mt_lo);
  assign go    = state == IDLE & start & ~kill;
  assign sgn   = op == MD_MULT || op == MD_DIV;
  assign a_abs = sgn & rs_val[WIDTH-1] ? -rs_val : rs_val;
  assign b_abs = sgn & rt_val[WIDTH-1] ? -rt_val : rt_val;
  assign prod  = neg_a ^ neg_b ? -acc : acc;
  // a zero divisor leaves quotient all ones and remainder |rs|, so only the quotient sign flip is suppressed
  assign quo   = (neg_a ^ neg_b) & ~dz ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem   = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  muldiv_step #(.WIDTH(WIDTH)) u_step (.is_div(is_div), .acc(acc), .opnd(opnd), .nxt(acc_nxt));
  always_comb begin
    state_nxt = kill ? IDLE
              : state == IDLE ? (start ? CALC : IDLE)
              : state == CALC ? (cnt == CW'(WIDTH-1) ? FIX : CALC)
              : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        cnt    <= '0;
        is_div <= op[1];
        neg_a  <= sgn & rs_val[WIDTH-1];
        neg_b  <= sgn & rt_val[WIDTH-1];
        dz     <= rt_val == '0;
        opnd   <= op[1] ? b_abs : a_abs;
        acc    <= {{WIDTH{1'b0}}, op[1] ? a_abs : b_abs};
      end else if (!kill && state == CALC) begin
        cnt <= cnt + 1'b1;
        acc <= acc_nxt;
      end else if (!kill && state == FIX) begin
        hi   <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
        lo   <= is_div ? quo : prod[WIDTH-1:0];
        done <= 1'b1;
      end else if (!kill && state == IDLE) begin
        if (mt_hi) hi <= mt_data;
        if (mt_lo) lo <= mt_data;
      end
    end
  end
endmodule
